demultiplexor_1in_3out_reg: RTL and testbench
=============================================

Name: demultiplexor_1in_3out_reg

Overview:
- Registered 1-to-3 demultiplexer. It is the write-side counterpart of the 3-to-1 data-select mux in the datapath.
- Takes one DB-bit data word plus a 2-bit select under a valid/ready handshake and steers it into one of three buffered output channels (A, B, C), each with its own valid/ready.
- Used where a single producer (ALU/result bus) feeds three destinations (accumulator, memory write port, output latch) that can each stall independently.

Parameters:
- DB, 16, data width in bits of input and all outputs.
- CW, 8, width of the illegal-select drop counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- DatoIn  input  DB  input data word
- Sel  input  2  destination select: 2 -> A, 1 -> B, 0 -> C, 3 -> illegal
- InValid  input  1  DatoIn/Sel valid
- InReady  output  1  block accepts word this cycle
- SalidaA / SalidaB / SalidaC  output  DB  channel data
- ValidA / ValidB / ValidC  output  1  channel holds a word
- ReadyA / ReadyB / ReadyC  input  1  consumer takes channel word
- DropCount  output  CW  saturating count of illegal-select words dropped

Behaviour:
- Reset (async, rst_n=0): all Valid* = 0, Salida* = 0, DropCount = 0, all channel buffers empty. Reset mid-transfer discards every buffered word.
- Transfers:
  - Input transfer when InValid && InReady at a rising clk.
  - Channel transfer when Valid* && Ready* at a rising clk.
- Latency: an accepted word appears on the selected channel with Valid high the cycle after acceptance. Zero-cycle bypass is forbidden.
- Routing: Sel=2 -> A, 1 -> B, 0 -> C. Non-selected channels are untouched.
- Sel=3:
  - InReady=1 unconditionally; the word is accepted and discarded.
  - DropCount increments by 1 and saturates at 2^CW-1; no wrap.
- InReady (legal Sel, base build) = !Valid_x || Ready_x for the selected channel x. This is combinational through Ready_x, so a full channel drained and refilled in the same cycle sustains 1 word/cycle.
- InReady depends on Sel/InValid combinationally. A producer holding InValid must keep DatoIn/Sel stable until accepted.
- Per channel each cycle:
  - Load and drain in the same cycle: the new word replaces the old one, Valid stays 1.
  - Drain only: Valid goes to 0, Salida holds its last value.
  - Load only: Valid goes to 1.
- Salida* must be stable while Valid*=1 && Ready*=0.
- Independence: back-pressure on one channel never blocks words routed to another channel.
- No FSM beyond per-channel occupancy: EMPTY/FULL in the base build; EMPTY/ONE/TWO with the skid option.

Optional Feature:
- Macro DEMUX_SKID_EN.
- Defined:
  - Each channel is a 2-entry FIFO (skid buffer).
  - InReady = selected channel has fewer than 2 entries, from registered state only; no combinational path from Ready* to InReady.
  - Throughput stays 1 word/cycle per channel; order is preserved within each channel.
  - Latency is still 1 cycle.
- Undefined: the 1-entry behaviour described above.

Decomposition:
- Shared package:
  - select encodings SEL_C=2'd0, SEL_B=2'd1, SEL_A=2'd2, SEL_ILLEGAL=2'd3
  - default DB=16 and CW=8
- One natural sub-module: demux_out_slot.
  - Per-channel buffer with ports: load, data in, valid, ready, data out, can_accept.
  - Contains the DEMUX_SKID_EN variation.
  - Instantiated three times.

Test Plan:
- Reset then send 0x1234/Sel=2, 0xABCD/Sel=1, 0x0F0F/Sel=0, all Ready=1 -> each word appears on A, B, C respectively one cycle after its acceptance; other Valids stay 0.
- ReadyA=0, send two words to A (0x0001, 0x0002) -> base: second word stalls (InReady=0) until ReadyA=1; skid: both accepted, drained in order 0x0001 then 0x0002; a third word to A stalls.
- ReadyA=0 with A full, then a word to B (0x5555) -> accepted immediately; appears on B next cycle.
- 300 consecutive Sel=3 words -> InReady always 1, no channel Valid rises, DropCount saturates at 255.
- Stream of 8 words to C with ReadyC=1 every cycle -> 8 transfers in 8 consecutive cycles; data order preserved.
- Assert rst_n=0 mid-stream with A and B full -> all Valid drop immediately (asynchronously); DropCount=0; after release the first new word routes normally.

Source files
------------

// File: rtl/demultiplexor_1in_3out_reg_pkg.sv
// Shared definitions for the registered 1-to-3 demultiplexer.
// Optional build macro DEMUX_SKID_EN selects 2-entry channel buffers.
package demultiplexor_1in_3out_reg_pkg;

  localparam int unsigned DefaultDb = 16;
  localparam int unsigned DefaultCw = 8;

  // Destination select encodings
  localparam logic [1:0] SEL_C       = 2'd0;
  localparam logic [1:0] SEL_B       = 2'd1;
  localparam logic [1:0] SEL_A       = 2'd2;
  localparam logic [1:0] SEL_ILLEGAL = 2'd3;

  // Per-channel occupancy; OccTwo is only reachable with DEMUX_SKID_EN
  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccTwo   = 2'd2
  } occ_e;

  function automatic logic sel_is_illegal(input logic [1:0] sel);
    return sel == SEL_ILLEGAL;
  endfunction

endpackage

// File: rtl/demultiplexor_1in_3out_reg_if.sv
// Producer/consumer bundle of the 1-to-3 demultiplexer.
// The master side is the environment (producer plus three consumers); the slave side is the block.
interface demultiplexor_1in_3out_reg_if #(
  parameter int unsigned DB = 16,
  parameter int unsigned CW = 8
);

  logic [DB-1:0] DatoIn;
  logic [1:0]    Sel;
  logic          InValid;
  logic          InReady;
  logic [DB-1:0] SalidaA;
  logic [DB-1:0] SalidaB;
  logic [DB-1:0] SalidaC;
  logic          ValidA;
  logic          ValidB;
  logic          ValidC;
  logic          ReadyA;
  logic          ReadyB;
  logic          ReadyC;
  logic [CW-1:0] DropCount;

  modport master (
    output DatoIn, Sel, InValid, ReadyA, ReadyB, ReadyC,
    input  InReady, SalidaA, SalidaB, SalidaC, ValidA, ValidB, ValidC, DropCount
  );

  modport slave (
    input  DatoIn, Sel, InValid, ReadyA, ReadyB, ReadyC,
    output InReady, SalidaA, SalidaB, SalidaC, ValidA, ValidB, ValidC, DropCount
  );

endinterface

// File: rtl/demux_out_slot.sv
// One output channel buffer of the demultiplexer.
// Base build: single register (empty/full), can_accept is combinational through i_ready.
// DEMUX_SKID_EN: main register plus skid register, can_accept from registered occupancy only.
module demux_out_slot
  import demultiplexor_1in_3out_reg_pkg::*;
#(
  parameter int unsigned DB = DefaultDb
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [DB-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DB-1:0] o_data,
  output logic          o_can_accept
);

  occ_e          r_occ;
  occ_e          w_occ_next;
  logic [DB-1:0] r_data;
  logic [DB-1:0] w_data_next;

`ifdef DEMUX_SKID_EN
  logic [DB-1:0] r_skid;
  logic [DB-1:0] w_skid_next;

  // Occupancy and data next-state; the skid register only fills while the head word stalls
  always_comb begin
    w_occ_next  = r_occ;
    w_data_next = r_data;
    w_skid_next = r_skid;
    unique case (r_occ)
      OccEmpty: begin
        if (i_load) begin
          w_data_next = i_data;
          w_occ_next  = OccOne;
        end
      end
      OccOne: begin
        if (i_load && i_ready) begin
          w_data_next = i_data;
        end else if (i_load) begin
          w_skid_next = i_data;
          w_occ_next  = OccTwo;
        end else if (i_ready) begin
          w_occ_next = OccEmpty;
        end
      end
      OccTwo: begin
        if (i_ready) begin
          w_data_next = r_skid;
          w_occ_next  = OccOne;
        end
      end
      default: w_occ_next = OccEmpty;
    endcase
    o_can_accept = (r_occ != OccTwo);
  end

  // Skid register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid <= '0;
    end else begin
      r_skid <= w_skid_next;
    end
  end
`else
  // Occupancy and data next-state; a load into a full slot only happens while it drains
  always_comb begin
    w_occ_next  = r_occ;
    w_data_next = r_data;
    unique case (r_occ)
      OccEmpty: begin
        if (i_load) begin
          w_data_next = i_data;
          w_occ_next  = OccOne;
        end
      end
      OccOne: begin
        if (i_load) begin
          w_data_next = i_data;
        end else if (i_ready) begin
          w_occ_next = OccEmpty;
        end
      end
      default: w_occ_next = OccEmpty;
    endcase
    o_can_accept = (r_occ == OccEmpty) || i_ready;
  end
`endif

  // Occupancy and head data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ  <= OccEmpty;
      r_data <= '0;
    end else begin
      r_occ  <= w_occ_next;
      r_data <= w_data_next;
    end
  end

  assign o_valid = (r_occ != OccEmpty);
  assign o_data  = r_data;

endmodule

// File: rtl/demultiplexor_1in_3out_reg.sv
// Registered 1-to-3 demultiplexer: steers one word per cycle into channel A, B or C by Sel,
// drops Sel=3 words and counts them in a saturating counter.
// Build macro DEMUX_SKID_EN turns each channel into a 2-entry skid buffer.
module demultiplexor_1in_3out_reg
  import demultiplexor_1in_3out_reg_pkg::*;
#(
  parameter int unsigned DB = DefaultDb,
  parameter int unsigned CW = DefaultCw
) (
  input logic                         clk,
  input logic                         rst_n,
  demultiplexor_1in_3out_reg_if.slave io_bus
);

  logic          w_load_a;
  logic          w_load_b;
  logic          w_load_c;
  logic          w_can_a;
  logic          w_can_b;
  logic          w_can_c;
  logic          w_drop;
  logic [CW-1:0] r_drop_count;
  logic [CW-1:0] w_drop_count_next;

  // Ready towards the producer and per-channel load strobes
  always_comb begin
    io_bus.InReady = 1'b1;
    unique case (io_bus.Sel)
      SEL_A:   io_bus.InReady = w_can_a;
      SEL_B:   io_bus.InReady = w_can_b;
      SEL_C:   io_bus.InReady = w_can_c;
      default: io_bus.InReady = 1'b1;
    endcase
    w_load_a = io_bus.InValid && (io_bus.Sel == SEL_A) && w_can_a;
    w_load_b = io_bus.InValid && (io_bus.Sel == SEL_B) && w_can_b;
    w_load_c = io_bus.InValid && (io_bus.Sel == SEL_C) && w_can_c;
    w_drop   = io_bus.InValid && sel_is_illegal(io_bus.Sel);
  end

  // Saturating drop counter next-state
  always_comb begin
    w_drop_count_next = r_drop_count;
    if (w_drop && (r_drop_count != {CW{1'b1}})) begin
      w_drop_count_next = r_drop_count + 1'b1;
    end
  end

  // Drop counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= '0;
    end else begin
      r_drop_count <= w_drop_count_next;
    end
  end

  assign io_bus.DropCount = r_drop_count;

  demux_out_slot #(.DB(DB)) u_slot_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load_a),
    .i_data       (io_bus.DatoIn),
    .o_valid      (io_bus.ValidA),
    .i_ready      (io_bus.ReadyA),
    .o_data       (io_bus.SalidaA),
    .o_can_accept (w_can_a)
  );

  demux_out_slot #(.DB(DB)) u_slot_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load_b),
    .i_data       (io_bus.DatoIn),
    .o_valid      (io_bus.ValidB),
    .i_ready      (io_bus.ReadyB),
    .o_data       (io_bus.SalidaB),
    .o_can_accept (w_can_b)
  );

  demux_out_slot #(.DB(DB)) u_slot_c (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load_c),
    .i_data       (io_bus.DatoIn),
    .o_valid      (io_bus.ValidC),
    .i_ready      (io_bus.ReadyC),
    .o_data       (io_bus.SalidaC),
    .o_can_accept (w_can_c)
  );

endmodule

// File: tb/tb_demultiplexor_1in_3out_reg.sv
// Bench for the registered 1-to-3 demultiplexer: routing table plus drop, stream and reset sequences.
module tb_demultiplexor_1in_3out_reg;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demultiplexor_1in_3out_reg_if #(.DB(16), .CW(8)) bus ();

  demultiplexor_1in_3out_reg dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row: inputs applied for one cycle, InReady seen before the edge, outputs seen after it.
  // rdy and vld are ordered {A, B, C}.
  typedef struct packed {
    logic        v;
    logic [1:0]  sel;
    logic [15:0] d;
    logic [2:0]  rdy;
    logic        ir;
    logic [2:0]  vld;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d,
                       input logic [2:0] r);
    bus.InValid = v;
    bus.Sel     = s;
    bus.DatoIn  = d;
    bus.ReadyA  = r[2];
    bus.ReadyB  = r[1];
    bus.ReadyC  = r[0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 2'd2, 16'h0, 3'b111);

    //            v     sel   data      rdy     ir    vld     A         B         C
    vecs[0]  = '{1'b1, 2'd2, 16'h1234, 3'b111, 1'b1, 3'b100, 16'h1234, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 2'd1, 16'hABCD, 3'b111, 1'b1, 3'b010, 16'h1234, 16'hABCD, 16'h0000};
    vecs[2]  = '{1'b1, 2'd0, 16'h0F0F, 3'b111, 1'b1, 3'b001, 16'h1234, 16'hABCD, 16'h0F0F};
    vecs[3]  = '{1'b0, 2'd0, 16'h0000, 3'b111, 1'b1, 3'b000, 16'h1234, 16'hABCD, 16'h0F0F};
    vecs[4]  = '{1'b1, 2'd2, 16'h0001, 3'b011, 1'b1, 3'b100, 16'h0001, 16'hABCD, 16'h0F0F};
`ifdef DEMUX_SKID_EN
    vecs[5]  = '{1'b1, 2'd2, 16'h0002, 3'b011, 1'b1, 3'b100, 16'h0001, 16'hABCD, 16'h0F0F};
    vecs[6]  = '{1'b1, 2'd2, 16'h0003, 3'b011, 1'b0, 3'b100, 16'h0001, 16'hABCD, 16'h0F0F};
`else
    vecs[5]  = '{1'b1, 2'd2, 16'h0002, 3'b011, 1'b0, 3'b100, 16'h0001, 16'hABCD, 16'h0F0F};
    vecs[6]  = '{1'b1, 2'd2, 16'h0002, 3'b011, 1'b0, 3'b100, 16'h0001, 16'hABCD, 16'h0F0F};
`endif
    vecs[7]  = '{1'b1, 2'd1, 16'h5555, 3'b011, 1'b1, 3'b110, 16'h0001, 16'h5555, 16'h0F0F};
`ifdef DEMUX_SKID_EN
    vecs[8]  = '{1'b1, 2'd2, 16'h0003, 3'b111, 1'b0, 3'b100, 16'h0002, 16'h5555, 16'h0F0F};
    vecs[9]  = '{1'b1, 2'd2, 16'h0003, 3'b111, 1'b1, 3'b100, 16'h0003, 16'h5555, 16'h0F0F};
    vecs[10] = '{1'b0, 2'd0, 16'h0000, 3'b111, 1'b1, 3'b000, 16'h0003, 16'h5555, 16'h0F0F};
`else
    vecs[8]  = '{1'b1, 2'd2, 16'h0002, 3'b111, 1'b1, 3'b100, 16'h0002, 16'h5555, 16'h0F0F};
    vecs[9]  = '{1'b0, 2'd0, 16'h0000, 3'b111, 1'b1, 3'b000, 16'h0002, 16'h5555, 16'h0F0F};
    vecs[10] = '{1'b0, 2'd0, 16'h0000, 3'b111, 1'b1, 3'b000, 16'h0002, 16'h5555, 16'h0F0F};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_valid", {29'd0, bus.ValidA, bus.ValidB, bus.ValidC}, 32'd0);
    check("reset_salida_a", {16'd0, bus.SalidaA}, 32'd0);
    check("reset_salida_b", {16'd0, bus.SalidaB}, 32'd0);
    check("reset_salida_c", {16'd0, bus.SalidaC}, 32'd0);
    check("reset_drop", {24'd0, bus.DropCount}, 32'd0);
    check("reset_in_ready", {31'd0, bus.InReady}, 32'd1);

    // Routing, back-pressure and independence table
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].rdy);
      #1;
      check($sformatf("row%0d_in_ready", i), {31'd0, bus.InReady}, {31'd0, vecs[i].ir});
      @(posedge clk);
      #1;
      check($sformatf("row%0d_valid", i), {29'd0, bus.ValidA, bus.ValidB, bus.ValidC},
            {29'd0, vecs[i].vld});
      check($sformatf("row%0d_salida_a", i), {16'd0, bus.SalidaA}, {16'd0, vecs[i].a});
      check($sformatf("row%0d_salida_b", i), {16'd0, bus.SalidaB}, {16'd0, vecs[i].b});
      check($sformatf("row%0d_salida_c", i), {16'd0, bus.SalidaC}, {16'd0, vecs[i].c});
    end

    // Illegal select: always accepted, never routed, counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1'b1, 2'd3, i[15:0], 3'b000);
      #1;
      check("drop_in_ready", {31'd0, bus.InReady}, 32'd1);
      @(posedge clk);
      #1;
      check("drop_valid", {29'd0, bus.ValidA, bus.ValidB, bus.ValidC}, 32'd0);
      if (i == 4) check("drop_count_5", {24'd0, bus.DropCount}, 32'd5);
      if (i == 254) check("drop_count_255", {24'd0, bus.DropCount}, 32'd255);
    end
    check("drop_count_sat", {24'd0, bus.DropCount}, 32'd255);

    // Back-to-back stream into C
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 2'd0, 16'hC000 + 16'(i), 3'b111);
      #1;
      check("stream_in_ready", {31'd0, bus.InReady}, 32'd1);
      @(posedge clk);
      #1;
      check("stream_valid_c", {31'd0, bus.ValidC}, 32'd1);
      check("stream_salida_c", {16'd0, bus.SalidaC}, {16'd0, 16'hC000 + 16'(i)});
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0, 3'b111);
    @(posedge clk);
    #1;
    check("stream_drained_c", {31'd0, bus.ValidC}, 32'd0);

    // Asynchronous reset with A and B holding words
    @(negedge clk);
    drive(1'b1, 2'd2, 16'h1111, 3'b000);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 2'd1, 16'h2222, 3'b000);
    @(posedge clk);
    #1;
    check("prereset_valid", {29'd0, bus.ValidA, bus.ValidB, bus.ValidC}, 32'b110);
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", {29'd0, bus.ValidA, bus.ValidB, bus.ValidC}, 32'd0);
    check("async_reset_drop", {24'd0, bus.DropCount}, 32'd0);
    check("async_reset_salida_a", {16'd0, bus.SalidaA}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'd0, 16'h7777, 3'b111);
    #1;
    check("postreset_in_ready", {31'd0, bus.InReady}, 32'd1);
    @(posedge clk);
    #1;
    check("postreset_valid", {29'd0, bus.ValidA, bus.ValidB, bus.ValidC}, 32'b001);
    check("postreset_salida_c", {16'd0, bus.SalidaC}, 32'h7777);
    check("postreset_salida_a", {16'd0, bus.SalidaA}, 32'd0);
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0, 3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
